// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the fetch-stage branch predictor: counter encodings,
// default table index widths and the conditional-branch opcode fields.
package branch_predictor_pkg;

    typedef enum logic [1:0] {
        CNT_SNT = 2'b00,
        CNT_WNT = 2'b01,
        CNT_WT  = 2'b10,
        CNT_ST  = 2'b11
    } cnt_e;

    localparam int BHT_IDX_W_DEFAULT = 6;
    localparam int BTB_IDX_W_DEFAULT = 4;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_BNE     = 3'b001;
    localparam logic [2:0] F3_BLT     = 3'b100;
    localparam logic [2:0] F3_BGE     = 3'b101;
    localparam logic [2:0] F3_BLTU    = 3'b110;
    localparam logic [2:0] F3_BGEU    = 3'b111;

    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// Next-state function of a 2-bit saturating direction counter.
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  logic [1:0] cnt,
    input  logic       taken,
    output logic [1:0] cnt_next
);

    // Step toward taken/not-taken, pinning at the strong states.
    always_comb begin
        cnt_next = cnt;
        case (cnt)
            CNT_SNT: cnt_next = taken ? CNT_WNT : CNT_SNT;
            CNT_WNT: cnt_next = taken ? CNT_WT  : CNT_SNT;
            CNT_WT:  cnt_next = taken ? CNT_ST  : CNT_WNT;
            CNT_ST:  cnt_next = taken ? CNT_ST  : CNT_WT;
            default: cnt_next = CNT_WNT;
        endcase
    end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal branch predictor with direct-mapped BTB, IF->ID prediction register
// and decode-stage misprediction detection.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int BHT_IDX_W = BHT_IDX_W_DEFAULT,
    parameter int BTB_IDX_W = BTB_IDX_W_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        id_stall,
    input  logic        id_flush,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    output logic        mispredict,
    output logic [31:0] redirect_pc
);

    localparam int BHT_N = 1 << BHT_IDX_W;
    localparam int BTB_N = 1 << BTB_IDX_W;
    localparam int TAG_W = 32 - BTB_IDX_W - 2;

    logic [1:0]       bht_r        [BHT_N];
    logic             btb_valid_r  [BTB_N];
    logic [TAG_W-1:0] btb_tag_r    [BTB_N];
    logic [31:0]      btb_target_r [BTB_N];

    logic             q_taken_r;
    logic [31:0]      q_target_r;
    logic [31:0]      q_fall_r;

    logic [BHT_IDX_W-1:0] if_bht_idx_s;
    logic [BHT_IDX_W-1:0] upd_bht_idx_s;
    logic [BTB_IDX_W-1:0] if_btb_idx_s;
    logic [BTB_IDX_W-1:0] upd_btb_idx_s;
    logic [TAG_W-1:0]     if_tag_s;
    logic [TAG_W-1:0]     upd_tag_s;
    logic [31:0]          if_fall_s;
    logic [1:0]           bht_next_s;
    logic                 btb_hit_s;
    logic                 pred_taken_s;
    logic [31:0]          pred_target_s;
    logic                 unused_s;

    assign if_bht_idx_s  = if_pc[BHT_IDX_W+1:2];
    assign upd_bht_idx_s = upd_pc[BHT_IDX_W+1:2];
    assign if_btb_idx_s  = if_pc[BTB_IDX_W+1:2];
    assign upd_btb_idx_s = upd_pc[BTB_IDX_W+1:2];
    assign if_tag_s      = if_pc[31:BTB_IDX_W+2];
    assign upd_tag_s     = upd_pc[31:BTB_IDX_W+2];
    assign if_fall_s     = pc_plus4(if_pc);
    assign unused_s      = ^upd_pc[1:0];

    sat_counter2 u_sat_counter2 (
        .cnt      (bht_r[upd_bht_idx_s]),
        .taken    (upd_taken),
        .cnt_next (bht_next_s)
    );

    // Direction table: every resolved branch trains its counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BHT_N; i++) begin
                bht_r[i] <= CNT_WNT;
            end
        end else if (upd_valid) begin
            bht_r[upd_bht_idx_s] <= bht_next_s;
        end
    end

    // Target buffer: only taken branches allocate; not-taken leaves it intact.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BTB_N; i++) begin
                btb_valid_r[i]  <= 1'b0;
                btb_tag_r[i]    <= '0;
                btb_target_r[i] <= 32'd0;
            end
        end else if (upd_valid && upd_taken) begin
            btb_valid_r[upd_btb_idx_s]  <= 1'b1;
            btb_tag_r[upd_btb_idx_s]    <= upd_tag_s;
            btb_target_r[upd_btb_idx_s] <= upd_target;
        end
    end

    // Fetch-stage lookup; reads see pre-edge state, so no write bypass.
    always_comb begin
        btb_hit_s    = btb_valid_r[if_btb_idx_s] && (btb_tag_r[if_btb_idx_s] == if_tag_s);
        pred_taken_s = btb_hit_s && bht_r[if_bht_idx_s][1];
        if (pred_taken_s) begin
            pred_target_s = btb_target_r[if_btb_idx_s];
        end else begin
            pred_target_s = if_fall_s;
        end
    end

    assign pred_taken  = pred_taken_s;
    assign pred_target = pred_target_s;

    // IF->ID prediction register; flush wins over stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_taken_r  <= 1'b0;
            q_target_r <= 32'd0;
            q_fall_r   <= 32'd0;
        end else if (id_flush) begin
            q_taken_r  <= 1'b0;
            q_target_r <= 32'd0;
            q_fall_r   <= 32'd0;
        end else if (!id_stall) begin
            q_taken_r  <= pred_taken_s;
            q_target_r <= pred_target_s;
            q_fall_r   <= if_fall_s;
        end
    end

    // Resolution compare against the held prediction.
    always_comb begin
        if (upd_valid) begin
            mispredict = (upd_taken != q_taken_r) || (upd_taken && (upd_target != q_target_r));
        end else begin
            mispredict = 1'b0;
        end
        if (upd_taken) begin
            redirect_pc = upd_target;
        end else begin
            redirect_pc = q_fall_r;
        end
    end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter BHT_IDX_W, default 6, sets the number of BHT index bits (64 entries).
REQ-002 Parameter BTB_IDX_W, default 4, sets the number of BTB index bits (16 entries, direct-mapped).
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 if_pc  input  32  fetch-stage PC being predicted.
REQ-006 pred_taken  output  1  fetch-stage prediction, combinational from if_pc and table state.
REQ-007 pred_target  output  32  next-fetch PC chosen by the prediction.
REQ-008 id_stall  input  1  hold the IF->ID prediction register.
REQ-009 id_flush  input  1  clear the IF->ID prediction register.
REQ-010 upd_valid  input  1  decode stage holds a resolved conditional branch this cycle.
REQ-011 upd_pc  input  32  PC of the resolved branch.
REQ-012 upd_taken  input  1  resolved outcome from the decode-stage branch comparator.
REQ-013 upd_target  input  32  resolved branch target.
REQ-014 mispredict  output  1  the held prediction disagrees with the resolution.
REQ-015 redirect_pc  output  32  correct next PC when mispredict=1.

Function
REQ-016 BHT entry = 2-bit saturating counter indexed by pc[BHT_IDX_W+1:2].
REQ-017 BTB entry = valid bit, tag pc[31:BTB_IDX_W+2] and 32-bit target, indexed by pc[BTB_IDX_W+1:2].
REQ-018 btb_hit = entry valid AND tag match for if_pc.
REQ-019 pred_taken = btb_hit AND BHT counter bit 1.
REQ-020 pred_target = BTB target when pred_taken=1, else if_pc+4 (mod 2^32).
REQ-021 When upd_valid=1, the counter at upd_pc increments on upd_taken=1 and decrements on upd_taken=0, saturating at 3 and 0.
REQ-022 When upd_valid=1 and upd_taken=1, the BTB entry at upd_pc is written (valid=1, tag, upd_target), overwriting any existing entry.
REQ-023 A not-taken update does not modify the BTB.
REQ-024 Table writes become visible to predictions on the cycle after the update edge; a same-cycle read of the index being written returns the old value (no bypass).
REQ-025 IF->ID register holds q_taken, q_target and q_fall (if_pc+4).
REQ-026 On a clock edge: id_flush=1 clears q_taken to 0 and q_target/q_fall to 0; otherwise id_stall=1 holds the register; otherwise it loads the current prediction.
REQ-027 id_flush has priority over id_stall.
REQ-028 mispredict = upd_valid AND ((upd_taken != q_taken) OR (upd_taken AND upd_target != q_target)); the output is combinational.
REQ-029 redirect_pc = upd_target when upd_taken=1, else q_fall.
REQ-030 mispredict is 0 whenever upd_valid=0; redirect_pc is then don't-care but deterministic.

Reset
REQ-031 On rst: all BHT counters = 2'b01 (weakly not-taken), all BTB valid bits = 0, and q_taken/q_target/q_fall = 0.
REQ-032 Reset asserted mid-operation discards any pending update on that edge; no table write occurs while rst=1.
REQ-033 Immediately after reset, pred_taken=0, pred_target=if_pc+4 and mispredict=0.

Structure
REQ-034 Counter encodings (SNT=00, WNT=01, WT=10, ST=11) and default index widths live in the shared defines header alongside the branch opcode defines.
REQ-035 Implement one sub-module, sat_counter2, as a combinational next-state function for the 2-bit counter; tables stay in the top module.

Verification
REQ-036 After reset, if_pc=0x00400010 -> pred_taken=0, pred_target=0x00400014.
REQ-037 Two updates with upd_pc=0x00400010, upd_taken=1, upd_target=0x00400100 -> counter=11; next cycle if_pc=0x00400010 -> pred_taken=1, pred_target=0x00400100.
REQ-038 Held q_taken=1, q_target=0x00400100; upd_valid=1, upd_taken=0 -> mispredict=1, redirect_pc=q_fall (0x00400014).
REQ-039 Four updates taken=0 on the trained entry -> counter saturates at 00, pred_taken=0, BTB entry remains valid.
REQ-040 Aliasing check: train 0x00400010 taken, then fetch 0x00400050 (same BTB index, different tag) -> pred_taken=0.
REQ-041 id_stall=1 and id_flush=1 together -> q_taken=0 next cycle; rst pulse mid-training -> all predictions return to not-taken.
